cluster_frame_sequencer: RTL and testbench

Frames hit-map rows for the downstream cluster counter and collects its count. Accepts rows over a valid/ready stream and emits them on the counter's row input between header and trailer words (alternating 1010… / 0101…). It guards against rows that alias the framing words, samples the counter's nturn result at a fixed latency, and publishes one result record per event. It sits between the trigger-side hit-map buffer and the cluster counter.

---
 rtl/cluster_frame_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_cluster_frame_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cluster_frame_sequencer.sv
// Frames hit-map rows between HEAD/TRAIL words for the cluster counter,
// samples the counter's nturn at a fixed latency and publishes one result per event.
module cluster_frame_sequencer #(
    parameter int MAPSIZE    = 38,
    parameter int MAX_ROWS   = 16,
    parameter int RESULT_LAT = 4,
    parameter int GAP        = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               row_valid_i,
    input  logic [MAPSIZE:0]   row_data_i,
    input  logic               row_last_i,
    output logic               row_ready_o,
    output logic [MAPSIZE:0]   cc_array_o,
    input  logic [5:0]         cc_nturn_i,
    output logic               result_valid_o,
    output logic [5:0]         result_nturn_o,
    output logic [7:0]         result_nrows_o,
    output logic               result_overflow_o,
    output logic               result_gap_o,
    output logic               result_alias_o,
    output logic               busy_o
);

    // state   | meaning
    // IDLE    | waiting for a row to start an event
    // HEAD    | load HEAD word onto the counter input
    // ROWS    | forwarding rows, bubbles on stalls
    // TRAIL   | load TRAIL word
    // WAIT    | counting down to the nturn sample edge
    // PUBLISH | result_valid pulse
    // DRAIN   | discarding rows of a truncated event up to row_last
    // GAP     | quiet cycles before the next event
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_HEAD    = 3'd1;
    localparam logic [2:0] S_ROWS    = 3'd2;
    localparam logic [2:0] S_TRAIL   = 3'd3;
    localparam logic [2:0] S_WAIT    = 3'd4;
    localparam logic [2:0] S_PUBLISH = 3'd5;
    localparam logic [2:0] S_DRAIN   = 3'd6;
    localparam logic [2:0] S_GAP     = 3'd7;

    function automatic logic [MAPSIZE:0] alt_word(input logic odd);
        logic [MAPSIZE:0] w;
        for (int i = 0; i <= MAPSIZE; i++) w[i] = (i[0] == odd);
        return w;
    endfunction

    localparam logic [MAPSIZE:0] HEAD_W = alt_word(1'b0);
    localparam logic [MAPSIZE:0] TRAIL_W = alt_word(1'b1);
    localparam logic [MAPSIZE:0] BIT0_W = {{MAPSIZE{1'b0}}, 1'b1};
    localparam logic [7:0] MAX_N  = 8'(MAX_ROWS);
    localparam logic [7:0] LAT_M1 = 8'(RESULT_LAT - 1);
    localparam logic [7:0] GAP_M1 = 8'(GAP - 1);

    logic [2:0]       state_q, state_d;
    logic [MAPSIZE:0] cc_q, cc_d;
    logic [7:0]       nrows_q, nrows_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             ovf_q, ovf_d, gap_q, gap_d, alias_q, alias_d, pend_q, pend_d;
    logic [5:0]       res_nturn_q, res_nturn_d;
    logic [7:0]       res_nrows_q, res_nrows_d;
    logic             res_ovf_q, res_ovf_d, res_gap_q, res_gap_d, res_alias_q, res_alias_d;

    // Next-state and datapath decode for the framing sequence.
    always_comb begin
        state_d     = state_q;
        cc_d        = '0;
        nrows_d     = nrows_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        gap_d       = gap_q;
        alias_d     = alias_q;
        pend_d      = pend_q;
        res_nturn_d = res_nturn_q;
        res_nrows_d = res_nrows_q;
        res_ovf_d   = res_ovf_q;
        res_gap_d   = res_gap_q;
        res_alias_d = res_alias_q;
        case (state_q)
            S_IDLE: begin
                if (row_valid_i) begin
                    state_d = S_HEAD;
                    nrows_d = '0;
                    ovf_d   = 1'b0;
                    gap_d   = 1'b0;
                    alias_d = 1'b0;
                    pend_d  = 1'b0;
                end
            end
            S_HEAD: begin
                cc_d    = HEAD_W;
                state_d = S_ROWS;
            end
            S_ROWS: begin
                if (row_valid_i) begin
                    // A row matching a framing word would confuse the counter.
                    if (row_data_i == HEAD_W || row_data_i == TRAIL_W) begin
                        cc_d    = row_data_i ^ BIT0_W;
                        alias_d = 1'b1;
                    end else begin
                        cc_d = row_data_i;
                    end
                    if (nrows_q != MAX_N) nrows_d = nrows_q + 8'd1;
                    if (row_last_i) begin
                        state_d = S_TRAIL;
                    end else if (nrows_q + 8'd1 >= MAX_N) begin
                        state_d = S_TRAIL;
                        ovf_d   = 1'b1;
                        pend_d  = 1'b1;
                    end
                end else begin
                    gap_d = 1'b1;
                end
            end
            S_TRAIL: begin
                cc_d    = TRAIL_W;
                cnt_d   = LAT_M1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == 8'd0) begin
                    res_nturn_d = cc_nturn_i;
                    res_nrows_d = nrows_q;
                    res_ovf_d   = ovf_q;
                    res_gap_d   = gap_q;
                    res_alias_d = alias_q;
                    state_d     = S_PUBLISH;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_PUBLISH: begin
                cnt_d   = GAP_M1;
                state_d = pend_q ? S_DRAIN : S_GAP;
            end
            S_DRAIN: begin
                if (row_valid_i && row_last_i) begin
                    cnt_d   = GAP_M1;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (cnt_q == 8'd0) state_d = S_IDLE;
                else cnt_d = cnt_q - 8'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, counters and result registers; reset abandons any event in flight.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            cc_q        <= '0;
            nrows_q     <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            gap_q       <= 1'b0;
            alias_q     <= 1'b0;
            pend_q      <= 1'b0;
            res_nturn_q <= '0;
            res_nrows_q <= '0;
            res_ovf_q   <= 1'b0;
            res_gap_q   <= 1'b0;
            res_alias_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cc_q        <= cc_d;
            nrows_q     <= nrows_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            gap_q       <= gap_d;
            alias_q     <= alias_d;
            pend_q      <= pend_d;
            res_nturn_q <= res_nturn_d;
            res_nrows_q <= res_nrows_d;
            res_ovf_q   <= res_ovf_d;
            res_gap_q   <= res_gap_d;
            res_alias_q <= res_alias_d;
        end
    end

    assign row_ready_o       = (state_q == S_ROWS) || (state_q == S_DRAIN);
    assign busy_o            = (state_q != S_IDLE);
    assign result_valid_o    = (state_q == S_PUBLISH);
    assign cc_array_o        = cc_q;
    assign result_nturn_o    = res_nturn_q;
    assign result_nrows_o    = res_nrows_q;
    assign result_overflow_o = res_ovf_q;
    assign result_gap_o      = res_gap_q;
    assign result_alias_o    = res_alias_q;

endmodule

// File: tb/tb_cluster_frame_sequencer.sv
// Directed bench for cluster_frame_sequencer with frame/result scoreboards
// and a cluster-counter stand-in that presents nturn only on the sample cycle.
module tb_cluster_frame_sequencer;

    localparam int MAPSIZE = 38;
    localparam int W       = MAPSIZE + 1;
    localparam int MAXR    = 4;
    localparam int LAT     = 4;
    localparam int GAPC    = 2;

    typedef struct {
        logic [5:0] nt;
        logic [7:0] nr;
        logic       ov;
        logic       gp;
        logic       al;
    } res_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         row_valid = 1'b0;
    logic [W-1:0] row_data = '0;
    logic         row_last = 1'b0;
    logic         row_ready;
    logic [W-1:0] cc_array;
    logic [5:0]   cc_nturn = 6'h2A;
    logic         result_valid;
    logic [5:0]   result_nturn;
    logic [7:0]   result_nrows;
    logic         result_overflow, result_gap, result_alias, busy;

    int pass_cnt = 0;
    int total    = 0;
    int b2b_meas = 0;

    logic [W-1:0] exp_frame[$];
    res_t         exp_res[$];
    logic [5:0]   nturn_q[$];
    logic [W-1:0] head_w, trail_w;

    cluster_frame_sequencer #(.MAPSIZE(MAPSIZE), .MAX_ROWS(MAXR), .RESULT_LAT(LAT), .GAP(GAPC)) dut (
        .clk_i(clk), .reset_i(rst), .row_valid_i(row_valid), .row_data_i(row_data),
        .row_last_i(row_last), .row_ready_o(row_ready), .cc_array_o(cc_array),
        .cc_nturn_i(cc_nturn), .result_valid_o(result_valid), .result_nturn_o(result_nturn),
        .result_nrows_o(result_nrows), .result_overflow_o(result_overflow),
        .result_gap_o(result_gap), .result_alias_o(result_alias), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Called just after a negedge; returns just after the negedge following acceptance.
    task automatic send_row(input logic [W-1:0] d, input logic l);
        int n = 0;
        row_valid = 1'b1;
        row_data  = d;
        row_last  = l;
        while (!row_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("row_accept_timeout", 64'(n < 300), 64'd1);
        @(negedge clk);
    endtask

    task automatic push_ev(input logic [5:0] nt, input logic [7:0] nr,
                           input logic ov, input logic gp, input logic al);
        res_t r;
        r.nt = nt; r.nr = nr; r.ov = ov; r.gp = gp; r.al = al;
        exp_res.push_back(r);
        nturn_q.push_back(nt);
    endtask

    task automatic wait_done();
        int n = 0;
        while ((exp_res.size() != 0 || busy) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("event_done_timeout", 64'(n < 500), 64'd1);
    endtask

    // Monitor: frame scoreboard, counter stand-in, result scoreboard, gap timing.
    initial begin
        logic         cap = 1'b0;
        logic         prev_rv = 1'b0;
        int           tcnt = 255;
        int           gm = 0;
        int           gc = 0;
        logic [W-1:0] e;
        res_t         r;
        forever begin
            @(negedge clk);
            if (rst) begin
                cap = 1'b0; tcnt = 255; gm = 0; prev_rv = 1'b0;
                cc_nturn = 6'h2A;
                continue;
            end
            if (tcnt < 255) tcnt++;
            if (!cap && cc_array == head_w) cap = 1'b1;
            if (cap) begin
                if (exp_frame.size() == 0) begin
                    chk("frame_underflow", 64'd1, 64'd0);
                    cap = 1'b0;
                end else begin
                    e = exp_frame.pop_front();
                    chk("cc_array", 64'(cc_array), 64'(e));
                    if (e == trail_w) begin
                        cap  = 1'b0;
                        tcnt = 0;
                    end
                end
            end else if (busy) begin
                chk("cc_zero_outside_frame", 64'(cc_array), 64'd0);
            end
            if (tcnt == LAT - 1 && nturn_q.size() != 0) cc_nturn = nturn_q.pop_front();
            else cc_nturn = 6'h2A;
            if (result_valid) begin
                chk("result_pulse_width", 64'(prev_rv), 64'd0);
                if (exp_res.size() == 0) begin
                    chk("result_underflow", 64'd1, 64'd0);
                end else begin
                    r = exp_res.pop_front();
                    chk("result_nturn", 64'(result_nturn), 64'(r.nt));
                    chk("result_nrows", 64'(result_nrows), 64'(r.nr));
                    chk("result_overflow", 64'(result_overflow), 64'(r.ov));
                    chk("result_gap", 64'(result_gap), 64'(r.gp));
                    chk("result_alias", 64'(result_alias), 64'(r.al));
                end
                if (b2b_meas > 0) begin
                    gm = 1;
                    gc = 0;
                end
            end else if (gm == 1) begin
                if (busy) gc++;
                else begin
                    chk("gap_cycles", 64'(gc), 64'(GAPC));
                    gm = (b2b_meas == 2) ? 2 : 0;
                    b2b_meas--;
                end
            end else if (gm == 2) begin
                chk("single_idle_then_head", 64'(busy), 64'd1);
                gm = 0;
            end
            prev_rv = result_valid;
        end
    end

    initial begin
        for (int i = 0; i < W; i++) begin
            head_w[i]  = (i % 2 == 0);
            trail_w[i] = (i % 2 == 1);
        end
        #1 rst = 1'b1;
        #2;
        chk("reset_cc_array", 64'(cc_array), 64'd0);
        chk("reset_row_ready", 64'(row_ready), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_result_valid", 64'(result_valid), 64'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);

        // Three rows, no stalls.
        exp_frame.push_back(head_w);
        exp_frame.push_back(W'(39'h1));
        exp_frame.push_back(W'(39'h4));
        exp_frame.push_back(W'(39'h10));
        exp_frame.push_back(trail_w);
        push_ev(6'd3, 8'd3, 1'b0, 1'b0, 1'b0);
        send_row(W'(39'h1), 1'b0);
        send_row(W'(39'h4), 1'b0);
        send_row(W'(39'h10), 1'b1);
        row_valid = 1'b0;
        wait_done();

        // Six rows against MAX_ROWS=4: truncation then drain.
        exp_frame.push_back(head_w);
        exp_frame.push_back(W'(39'h3));
        exp_frame.push_back(W'(39'h5));
        exp_frame.push_back(W'(39'h6));
        exp_frame.push_back(W'(39'h9));
        exp_frame.push_back(trail_w);
        push_ev(6'd5, 8'd4, 1'b1, 1'b0, 1'b0);
        send_row(W'(39'h3), 1'b0);
        send_row(W'(39'h5), 1'b0);
        send_row(W'(39'h6), 1'b0);
        send_row(W'(39'h9), 1'b0);
        send_row(W'(39'hA), 1'b0);
        send_row(W'(39'hC), 1'b1);
        row_valid = 1'b0;
        wait_done();
        chk("busy_after_drain_gap", 64'(busy), 64'd0);

        // Last on exactly the MAX_ROWS-th row: normal end.
        exp_frame.push_back(head_w);
        for (int i = 1; i <= 4; i++) exp_frame.push_back(W'(i * 16));
        exp_frame.push_back(trail_w);
        push_ev(6'd11, 8'd4, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) send_row(W'(i * 16), 1'(i == 4));
        row_valid = 1'b0;
        wait_done();

        // One stall cycle between two rows.
        exp_frame.push_back(head_w);
        exp_frame.push_back(W'(39'h11));
        exp_frame.push_back('0);
        exp_frame.push_back(W'(39'h22));
        exp_frame.push_back(trail_w);
        push_ev(6'd7, 8'd2, 1'b0, 1'b1, 1'b0);
        send_row(W'(39'h11), 1'b0);
        row_valid = 1'b0;
        @(negedge clk);
        send_row(W'(39'h22), 1'b1);
        row_valid = 1'b0;
        wait_done();

        // Rows equal to the framing words.
        exp_frame.push_back(head_w);
        exp_frame.push_back(head_w ^ W'(1));
        exp_frame.push_back(trail_w ^ W'(1));
        exp_frame.push_back(trail_w);
        push_ev(6'd1, 8'd2, 1'b0, 1'b0, 1'b1);
        send_row(head_w, 1'b0);
        send_row(trail_w, 1'b1);
        row_valid = 1'b0;
        wait_done();

        // Reset in the middle of ROWS after two rows.
        exp_frame.push_back(head_w);
        exp_frame.push_back(W'(39'h7));
        exp_frame.push_back(W'(39'h8));
        send_row(W'(39'h7), 1'b0);
        send_row(W'(39'h8), 1'b0);
        row_valid = 1'b0;
        chk("pre_reset_busy", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_cc_array", 64'(cc_array), 64'd0);
        chk("midrst_row_ready", 64'(row_ready), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_result_valid", 64'(result_valid), 64'd0);
        chk("midrst_result_fields",
            {43'd0, result_nturn, result_nrows, result_overflow, result_gap, result_alias}, 64'd0);
        @(negedge clk);
        exp_frame.delete();
        #2 rst = 1'b0;
        @(negedge clk);
        exp_frame.push_back(head_w);
        exp_frame.push_back(W'(39'h55));
        exp_frame.push_back(trail_w);
        push_ev(6'd9, 8'd1, 1'b0, 1'b0, 1'b0);
        send_row(W'(39'h55), 1'b1);
        row_valid = 1'b0;
        wait_done();

        // Back-to-back events with upstream always valid.
        b2b_meas = 2;
        exp_frame.push_back(head_w);
        exp_frame.push_back(W'(39'h100));
        exp_frame.push_back(trail_w);
        exp_frame.push_back(head_w);
        exp_frame.push_back(W'(39'h200));
        exp_frame.push_back(trail_w);
        push_ev(6'd12, 8'd1, 1'b0, 1'b0, 1'b0);
        push_ev(6'd21, 8'd1, 1'b0, 1'b0, 1'b0);
        send_row(W'(39'h100), 1'b1);
        send_row(W'(39'h200), 1'b1);
        row_valid = 1'b0;
        wait_done();
        repeat (4) @(negedge clk);

        chk("results_all_seen", 64'(exp_res.size()), 64'd0);
        chk("frames_all_seen", 64'(exp_frame.size()), 64'd0);
        chk("gap_measures_done", 64'(b2b_meas), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
